wb_trace_buffer: RTL
====================

// Module: wb_trace_buffer
// PURPOSE
//  Captures every architectural register write leaving the pipeline's writeback stage (regwrite, dest reg, data)
//  into a FIFO. A debug/console consumer drains it with a valid/ready handshake.
//  Sits directly downstream of the CPU top level; consumes its WB_RegWrite/WB_WriteReg/WB_WriteData outputs.
//  Never back-pressures the CPU: when full, new events are dropped and counted.
// PARAMETERS
//  DEPTH       16  FIFO entries; must be a power of 2, >= 2
//  DROP_CNT_W  8   width of the saturating dropped-event counter
//  TS_W        16  timestamp width (used only with WB_TRACE_TIMESTAMP_EN)
// PORTS
//  Clk            in   1             system clock, rising edge
//  Reset          in   1             asynchronous, active-high; clears all state
//  wb_regwrite    in   1             writeback write-enable from pipeline
//  wb_writereg    in   5             destination register index
//  wb_writedata   in   32            value being written
//  trace_en       in   1             1 = capture enabled, 0 = ignore writeback events
//  clear          in   1             synchronous flush of FIFO, drop counter and overflow flag
//  out_valid      out  1             head entry available
//  out_ready      in   1             consumer accepts head entry
//  out_reg        out  5             head entry register index
//  out_data       out  32            head entry data
//  out_ts         out  TS_W          head entry timestamp (0 when macro absent)
//  count          out  log2(DEPTH)+1 current occupancy
//  overflow       out  1             sticky: at least one event dropped since reset/clear
//  drop_cnt       out  DROP_CNT_W    dropped events, saturates at all-ones
// BEHAVIOUR
//  - Reset: pointers=0, count=0, out_valid=0, out_reg=0, out_data=0, out_ts=0, overflow=0, drop_cnt=0.
//  - Event = trace_en & wb_regwrite & (wb_writereg != 5'd0); writes to $0 are never captured.
//  - Push: event sampled at rising edge; entry visible at outputs the next cycle (latency 1).
//  - First-word-fall-through: out_valid = (count != 0); out_* show mem[rd_ptr] combinationally from registered storage.
//  - Pop occurs on the edge where out_valid & out_ready; out_ready while empty is ignored.
//  - Full and event, no pop: event dropped; overflow<=1; drop_cnt increments, saturating.
//  - Full and event with pop in the same cycle: both occur, no drop, count unchanged.
//  - Push and pop while non-full, non-empty: count unchanged; entries stay strictly in order.
//  - Pointers are log2(DEPTH) bits and wrap naturally; occupancy comes from the count register, not pointer compare.
//  - clear has priority over push/pop in the same cycle; the event arriving that cycle is discarded.
//  - Reset asserted mid-operation: all contents lost immediately (async); outputs at reset values until release.
//  - Storage has no reset requirement; only pointers, count and flags reset.
// CONFIGURATION
//  - WB_TRACE_TIMESTAMP_EN defined: free-running TS_W-bit cycle counter (reset 0, wraps).
//    Stored with each entry = counter value on the capture edge. clear does not reset the counter.
//  - Undefined: no counter, no timestamp storage; out_ts tied to 0.
// STRUCTURE
//  - Shared constants file (cpu_defs.vh): REG_IDX_W=5, DATA_W=32, REG_ZERO=5'd0.
//    Also defines the trace entry field layout {ts, reg, data} so consumers decode identically.
//  - One sub-module: wb_trace_fifo. Generic WIDTH/DEPTH FWFT FIFO with push/pop/clear/full/empty/count.
//    Top handles event qualification, drop accounting and timestamping.
// TESTING
//  1 Reset, then events r8=0x11, r9=0x22, out_ready=0 -> count=2, out_valid=1, out_reg=8, out_data=0x11.
//  2 Write to r0 (0xDEAD) with trace_en=1 -> count stays 0, out_valid=0; trace_en=0 with r5 write -> no capture.
//  3 DEPTH=16: 18 events, no pop -> count=16, overflow=1, drop_cnt=2, head still first event.
//  4 Full, event + out_ready same cycle -> count=16, drop_cnt unchanged, new entry at tail; drain 16 in order.
//  5 Wrap: 40 push/pop cycles one-in-one-out -> every out_data matches push order, count never >1.
//  6 clear with simultaneous event and pop -> next cycle count=0, overflow=0, drop_cnt=0.
//    Reset mid-drain -> out_valid=0 same cycle.
//    With WB_TRACE_TIMESTAMP_EN: events 3 cycles apart -> out_ts difference = 3.

Source files
------------

// File: rtl/wb_trace_buffer_pkg.sv
// Shared constants and trace entry layout for the writeback trace buffer.
// Consumers decode entries as {ts, regIdx, data}, with ts present only under WB_TRACE_TIMESTAMP_EN.
package wb_trace_buffer_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_IDX_W-1:0] regIdx;
        logic [DATA_W-1:0]    data;
    } traceEntryT;

    localparam int ENTRY_W = $bits(traceEntryT);

    // Writes to $0 have no architectural effect, so they are never traced.
    function automatic logic isTraceEvent(input logic enable, input logic regWrite,
                                          input logic [REG_IDX_W-1:0] regIdx);
        return enable & regWrite & (regIdx != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Generic first-word-fall-through FIFO with synchronous clear.
// Occupancy is tracked in its own register; pointers wrap naturally.
module wb_trace_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   occ;
    logic             doPush;
    logic             doPop;

    assign full   = (occ == (PTR_W+1)'(DEPTH));
    assign empty  = (occ == '0);
    assign doPop  = pop & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign doPush = push & (~full | doPop);
    assign count  = occ;
    assign rdData = empty ? '0 : mem[rdPtr];

    // Pointer and occupancy state; clear wins over any push/pop that cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   occ <= occ + (PTR_W+1)'(1);
                2'b01:   occ <= occ - (PTR_W+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (doPush && !clear) mem[wrPtr] <= wrData;
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback-stage trace buffer: qualifies register writes, queues them, counts drops when full.
// Optional per-entry timestamps are enabled with WB_TRACE_TIMESTAMP_EN.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DROP_CNT_W = 8,
    parameter int TS_W       = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    wb_regwrite,
    input  logic [REG_IDX_W-1:0]    wb_writereg,
    input  logic [DATA_W-1:0]       wb_writedata,
    input  logic                    trace_en,
    input  logic                    clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [REG_IDX_W-1:0]    out_reg,
    output logic [DATA_W-1:0]       out_data,
    output logic [TS_W-1:0]         out_ts,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int FIFO_W = TS_W + ENTRY_W;
`else
    localparam int FIFO_W = ENTRY_W;
`endif

    logic              traceEvent;
    logic              popReq;
    logic              dropEvent;
    logic              fifoFull;
    logic              fifoEmpty;
    logic [FIFO_W-1:0] wrData;
    logic [FIFO_W-1:0] rdData;
    traceEntryT        headEntry;

    assign traceEvent = isTraceEvent(trace_en, wb_regwrite, wb_writereg);
    assign popReq     = out_ready & ~fifoEmpty;
    assign dropEvent  = traceEvent & fifoFull & ~popReq & ~clear;

    assign headEntry = traceEntryT'(rdData[ENTRY_W-1:0]);
    assign out_valid = ~fifoEmpty;
    assign out_reg   = headEntry.regIdx;
    assign out_data  = headEntry.data;

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] tsCnt;

    // Free-running cycle counter; clear deliberately leaves it alone.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) tsCnt <= '0;
        else       tsCnt <= tsCnt + TS_W'(1);
    end

    assign wrData = {tsCnt, wb_writereg, wb_writedata};
    assign out_ts = rdData[FIFO_W-1 -: TS_W];
`else
    assign wrData = {wb_writereg, wb_writedata};
    assign out_ts = '0;
`endif

    wb_trace_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) fifo (
        .clock  (Clk),
        .reset  (Reset),
        .push   (traceEvent),
        .pop    (out_ready),
        .clear  (clear),
        .wrData (wrData),
        .rdData (rdData),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (count)
    );

    // Sticky overflow and saturating drop count, both flushed by clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (dropEvent) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

endmodule
